// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES-128 round sequencer.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } ctrl_state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Host handshake and datapath control bundle for aes_round_ctrl.
// The abort input exists only when AES_ABORT_EN is defined.
interface aes_round_ctrl_if #(
  parameter int RW = 4
);
  logic          start;
  logic          out_ack;
`ifdef AES_ABORT_EN
  logic          abort;
`endif
  logic          busy;
  logic          ld_state;
  logic          ld_key;
  logic          round_en;
  logic          last_round;
  logic [RW-1:0] round;
  logic [7:0]    rcon;
  logic          done;
  logic          out_valid;

`ifdef AES_ABORT_EN
  modport master (output start, out_ack, abort,
                  input  busy, ld_state, ld_key, round_en, last_round, round, rcon, done, out_valid);
  modport slave  (input  start, out_ack, abort,
                  output busy, ld_state, ld_key, round_en, last_round, round, rcon, done, out_valid);
`else
  modport master (output start, out_ack,
                  input  busy, ld_state, ld_key, round_en, last_round, round, rcon, done, out_valid);
  modport slave  (input  start, out_ack,
                  output busy, ld_state, ld_key, round_en, last_round, round, rcon, done, out_valid);
`endif
endinterface

// File: rtl/aes_rcon_gen.sv
// Round-constant register: clear loads 01, advance steps by xtime; clear wins.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_adv,
  output logic [7:0] o_rcon
);

  logic [7:0] r_rcon;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_rcon <= RCON_INIT;
    else if (i_clr) r_rcon <= RCON_INIT;
    else if (i_adv) r_rcon <= xtime(r_rcon);
  end

  assign o_rcon = r_rcon;

endmodule

// File: rtl/aes_round_ctrl.sv
// One-round-per-clock AES-128 sequencer: IDLE -> INIT -> ROUND -> FINAL -> DONE.
// Optional AES_ABORT_EN adds an abort input that returns any busy/done state to IDLE.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic            clk,
  input  logic            reset,
  aes_round_ctrl_if.slave bus
);

  ctrl_state_t   r_state, w_next;
  logic [RW-1:0] r_round;
  logic          r_done;
  logic          w_rcon_clr, w_rcon_adv;
  logic [7:0]    w_rcon;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = INIT;
      INIT:    w_next = (NR == 1) ? FINAL : ROUND;
      ROUND:   if (r_round == RW'(NR - 1)) w_next = FINAL;
      FINAL:   w_next = DONE;
      DONE:    if (bus.out_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
`ifdef AES_ABORT_EN
    if (bus.abort && (r_state != IDLE)) w_next = IDLE;
`endif
  end

  // Every return to IDLE (ack, abort, bad encoding) rewinds round and rcon.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 r_round <= '0;
    else if (w_next == IDLE)   r_round <= '0;
    else if (r_state == INIT)  r_round <= RW'(1);
    else if (r_state == ROUND) r_round <= r_round + RW'(1);
  end

  // done marks the first DONE cycle only; registered so it stays a Moore output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= (w_next == DONE) && (r_state != DONE);
  end

  assign w_rcon_clr = (w_next == IDLE) || (r_state == INIT);
  assign w_rcon_adv = (r_state == ROUND);

  aes_rcon_gen u_rcon (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_rcon_clr),
    .i_adv  (w_rcon_adv),
    .o_rcon (w_rcon)
  );

  always_comb begin
    bus.busy       = 1'b0;
    bus.ld_state   = 1'b0;
    bus.ld_key     = 1'b0;
    bus.round_en   = 1'b0;
    bus.last_round = 1'b0;
    bus.out_valid  = 1'b0;
    case (r_state)
      INIT:  begin bus.busy = 1'b1; bus.ld_state = 1'b1; bus.ld_key = 1'b1; end
      ROUND: begin bus.busy = 1'b1; bus.round_en = 1'b1; end
      FINAL: begin bus.busy = 1'b1; bus.round_en = 1'b1; bus.last_round = 1'b1; end
      DONE:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.round = r_round;
  assign bus.rcon  = w_rcon;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: directed table, FIPS-197 datapath model,
// corner sequences and randomized handshake traffic against a cycle-count reference model.
module tb_aes_round_ctrl;

  localparam int NR = 10;
  localparam int RW = 4;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  aes_round_ctrl_if #(.RW(RW)) bus();

  aes_round_ctrl #(.NR(NR), .RW(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: -1 idle, 0 the load cycle, 1..NR round cycles, >NR ciphertext held.
  int         m_cyc = -1;
  logic [7:0] rtab[NR+1];
  logic [7:0] sb[256];

  typedef logic [18:0] ovec_t;
  typedef struct {
    bit    st;
    bit    ack;
    ovec_t exp;
  } vec_t;

  function automatic ovec_t pk(bit busy, bit lds, bit ldk, bit ren, bit last,
                               int rnd, logic [7:0] rc, bit dn, bit ov);
    return {busy, lds, ldk, ren, last, 4'(rnd), rc, dn, ov};
  endfunction

  function automatic ovec_t obs();
    return {bus.busy, bus.ld_state, bus.ld_key, bus.round_en, bus.last_round,
            bus.round, bus.rcon, bus.done, bus.out_valid};
  endfunction

  function automatic ovec_t model_out();
    if (m_cyc < 0)   return pk(0, 0, 0, 0, 0, 0, 8'h01, 0, 0);
    if (m_cyc == 0)  return pk(1, 1, 1, 0, 0, 0, 8'h01, 0, 0);
    if (m_cyc <= NR) return pk(1, 0, 0, 1, m_cyc == NR, m_cyc, rtab[m_cyc], 0, 0);
    return pk(0, 0, 0, 0, 0, NR, rtab[NR], m_cyc == NR + 1, 1);
  endfunction

  task automatic model_step(input bit s, input bit a, input bit ab);
    if (m_cyc < 0)        begin if (s) m_cyc = 0; end
    else if (ab)          m_cyc = -1;
    else if (m_cyc <= NR) m_cyc++;
    else if (a)           m_cyc = -1;
    else if (m_cyc < 1000) m_cyc++;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input bit s, input bit a, input bit ab);
    bus.start   = s;
    bus.out_ack = a;
`ifdef AES_ABORT_EN
    bus.abort   = ab;
`endif
  endtask

  // One clock: drive at negedge, model follows the edge, compare at next negedge.
  task automatic cyc(input bit s, input bit a, input bit ab, input string name);
    drive(s, a, ab);
    @(posedge clk);
    model_step(s, a, ab);
    @(negedge clk);
    check(name, obs(), model_out());
  endtask

  // FIPS-197 datapath model driven by the controller's outputs.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sb[w3[23:16]], sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]} ^ {rc, 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic [127:0] k, input bit last);
    logic [7:0] a[16];
    logic [7:0] b[16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sb[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++) b[j+4*c] = a[j+4*((c+j)%4)];
    if (!last)
      for (int c = 0; c < 4; c++) begin
        for (int j = 0; j < 4; j++) a[j] = b[4*c+j];
        b[4*c]   = gm(a[0], 2) ^ gm(a[1], 3) ^ a[2] ^ a[3];
        b[4*c+1] = a[0] ^ gm(a[1], 2) ^ gm(a[2], 3) ^ a[3];
        b[4*c+2] = a[0] ^ a[1] ^ gm(a[2], 2) ^ gm(a[3], 3);
        b[4*c+3] = gm(a[0], 3) ^ a[1] ^ a[2] ^ gm(a[3], 2);
      end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i] ^ k[127-8*i -: 8];
    return r;
  endfunction

  logic [127:0] dp_st, dp_k;
  always @(posedge clk) begin
    logic [127:0] nk;
    if (bus.ld_state) begin
      dp_st <= PT ^ KEY;
      dp_k  <= KEY;
    end else if (bus.round_en) begin
      nk = key_exp(dp_k, bus.rcon);
      dp_st <= aes_rnd(dp_st, nk, bus.last_round);
      dp_k  <= nk;
    end
  end

  vec_t       tbl[15];
  logic [7:0] rc_lit[10];
  ovec_t      idlev;
  int         n, dcnt;
  bit         s, a, ab;

  initial begin
    // S-box from GF inverse plus affine map; rcon by repeated doubling mod 0x11b.
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    begin
      int v;
      v = 1;
      for (int i = 1; i <= NR; i++) begin
        rtab[i] = 8'(v);
        v = v << 1;
        if (v > 255) v = v ^ 'h11b;
      end
    end
    rtab[0] = 8'h01;

    rc_lit = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    idlev  = pk(0, 0, 0, 0, 0, 0, 8'h01, 0, 0);
    tbl[0] = '{1'b1, 1'b0, idlev};
    tbl[1] = '{1'b0, 1'b0, pk(1, 1, 1, 0, 0, 0, 8'h01, 0, 0)};
    for (int r = 1; r <= 10; r++)
      tbl[r+1] = '{1'b0, 1'b0, pk(1, 0, 0, 1, r == 10, r, rc_lit[r-1], 0, 0)};
    tbl[12] = '{1'b0, 1'b0, pk(0, 0, 0, 0, 0, 10, 8'h36, 1, 1)};
    tbl[13] = '{1'b0, 1'b1, pk(0, 0, 0, 0, 0, 10, 8'h36, 0, 1)};
    tbl[14] = '{1'b0, 1'b0, idlev};

    drive(0, 0, 0);
    reset = 1'b1;
    #1 check("reset_state", obs(), idlev);
    @(negedge clk) reset = 1'b0;
    @(negedge clk) check("idle_after_reset", obs(), idlev);

    // Full run: first ciphertext-valid cycle is row 12, i.e. 1 load + NR round cycles after the start edge.
    for (int i = 0; i < 15; i++) begin
      check($sformatf("tbl_row%0d", i), obs(), tbl[i].exp);
      drive(tbl[i].st, tbl[i].ack, 0);
      @(posedge clk);
      model_step(tbl[i].st, tbl[i].ack, 0);
      @(negedge clk);
    end

    // FIPS-197 vector through the datapath model; bounded wait for out_valid.
    cyc(1, 0, 0, "fips_start");
    n = 0;
    while (!bus.out_valid && n < 30) begin
      cyc(0, 0, 0, "fips_run");
      n++;
    end
    check("fips_latency", n, NR + 1);
    check("fips_ct", dp_st, CT);
    cyc(0, 1, 0, "fips_ack");

    // Async reset in the middle of round 5, then a clean full run.
    cyc(1, 0, 0, "rst_start");
    repeat (5) cyc(0, 0, 0, "rst_run");
    check("rst_round5", bus.round, 5);
    #2 reset = 1'b1;
    #1 check("rst_async", obs(), idlev);
    m_cyc = -1;
    @(negedge clk) reset = 1'b0;
    cyc(1, 0, 0, "rst_restart");
    repeat (NR + 2) cyc(0, 0, 0, "rst_rerun");
    cyc(0, 1, 0, "rst_ack");

    // start re-pulsed through ROUND, FINAL and DONE is ignored.
    cyc(1, 0, 0, "repulse_start");
    for (int k = 0; k < NR + 5; k++) cyc(k[0], 0, 0, "repulse_run");
    cyc(0, 1, 0, "repulse_ack");
    cyc(0, 0, 0, "repulse_idle");

    // Long hold without ack: one done pulse, out_valid steady; start+ack only returns to IDLE.
    cyc(1, 0, 0, "hold_start");
    dcnt = 0;
    repeat (NR + 21) begin
      cyc(0, 0, 0, "hold_run");
      dcnt += int'(bus.done);
    end
    check("hold_done_once", dcnt, 1);
    check("hold_valid", bus.out_valid, 1'b1);
    cyc(1, 1, 0, "hold_start_ack");
    cyc(0, 0, 0, "hold_no_init");

`ifdef AES_ABORT_EN
    cyc(1, 0, 0, "abort_start");
    repeat (3) cyc(0, 0, 0, "abort_run");
    check("abort_round3", bus.round, 3);
    cyc(0, 0, 1, "abort_hit");
    dcnt = 0;
    repeat (NR + 3) begin
      cyc(0, 0, 0, "abort_quiet");
      dcnt += int'(bus.done) + int'(bus.out_valid);
    end
    check("abort_no_done", dcnt, 0);
    cyc(1, 0, 1, "abort_start_in_idle");
    cyc(0, 0, 0, "abort_round1");
    check("abort_rcon1", {bus.round, bus.rcon}, {4'd1, 8'h01});
    cyc(0, 0, 1, "abort_again");
`endif

    repeat (400) begin
      s  = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 4) == 0);
`ifdef AES_ABORT_EN
      ab = ($urandom_range(0, 15) == 0);
`else
      ab = 1'b0;
`endif
      cyc(s, a, ab, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
